axi_packet_arb4: RTL and testbench

AXI_PACKET_ARB4 -- requirements
Module: axi_packet_arb4

---
 rtl/axi_packet_arb4_pkg.sv | 11 +
 rtl/rr_pick4.sv | 27 ++
 rtl/axi_packet_arb4.sv | 136 +++++++++++++
 tb/tb_axi_packet_arb4.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_packet_arb4_pkg.sv
// Shared definitions for the four-input AXI-stream packet arbiter.
package axi_packet_arb4_pkg;

    localparam int NUM_PORTS = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational cyclic priority picker: the first requester after 'last'
// (wrapping around, 'last' itself searched last) wins a one-hot grant.
module rr_pick4
    import axi_packet_arb4_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           last,
    output logic [NUM_PORTS-1:0] gnt
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = last;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_packet_arb4.sv
// Four-input AXI-stream packet arbiter: round-robin between packets,
// ownership held until the tlast beat is accepted, one registered output stage.
module axi_packet_arb4
    import axi_packet_arb4_pkg::*;
#(
    parameter int         WIDTH       = 16,
    parameter logic [3:0] ACTIVE_MASK = 4'b1111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i0_tdata,
    input  logic             i0_tlast,
    input  logic             i0_tvalid,
    output logic             i0_tready,
    input  logic [WIDTH-1:0] i1_tdata,
    input  logic             i1_tlast,
    input  logic             i1_tvalid,
    output logic             i1_tready,
    input  logic [WIDTH-1:0] i2_tdata,
    input  logic             i2_tlast,
    input  logic             i2_tvalid,
    output logic             i2_tready,
    input  logic [WIDTH-1:0] i3_tdata,
    input  logic             i3_tlast,
    input  logic             i3_tvalid,
    output logic             i3_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [3:0]       grant
);

    state_t             state, state_next;
    logic [3:0]         grant_next;
    logic [1:0]         last_grant, last_grant_next;
    logic [1:0]         grant_idx;
    logic [3:0]         valid_vec, ready_vec, pick;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_last;
    logic               can_accept, accept;

    // Disabled inputs are invisible to the arbiter and never see tready.
    assign valid_vec = {i3_tvalid, i2_tvalid, i1_tvalid, i0_tvalid} & ACTIVE_MASK;

    rr_pick4 u_pick (
        .req  (valid_vec),
        .last (last_grant),
        .gnt  (pick)
    );

    assign can_accept = !o_tvalid || o_tready;
    assign ready_vec  = (state == ST_BUSY && can_accept) ? (grant & ACTIVE_MASK) : 4'b0000;
    assign accept     = |(ready_vec & valid_vec);

    assign i0_tready = ready_vec[0];
    assign i1_tready = ready_vec[1];
    assign i2_tready = ready_vec[2];
    assign i3_tready = ready_vec[3];

    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        grant_idx = 2'd0;
        case (grant)
            4'b0001: begin grant_idx = 2'd0; sel_data = i0_tdata; sel_last = i0_tlast; end
            4'b0010: begin grant_idx = 2'd1; sel_data = i1_tdata; sel_last = i1_tlast; end
            4'b0100: begin grant_idx = 2'd2; sel_data = i2_tdata; sel_last = i2_tlast; end
            4'b1000: begin grant_idx = 2'd3; sel_data = i3_tdata; sel_last = i3_tlast; end
            default: ;
        endcase
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        case (state)
            ST_IDLE: begin
                grant_next = 4'b0000;
                if (|valid_vec) begin
                    grant_next = pick;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && sel_last) begin
                    state_next      = ST_IDLE;
                    grant_next      = 4'b0000;
                    last_grant_next = grant_idx;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = 4'b0000;
            end
        endcase
    end

    // last_grant resets to 3 so that input 0 is the first served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= 4'b0000;
            last_grant <= 2'd3;
        end else if (clear) begin
            state      <= ST_IDLE;
            grant      <= 4'b0000;
            last_grant <= 2'd3;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
        end
    end

    // Output stage reloads in the same cycle it drains, so packets stream at full rate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_tvalid <= 1'b0;
        end else if (clear) begin
            o_tlast  <= 1'b0;
            o_tvalid <= 1'b0;
        end else if (accept) begin
            o_tdata  <= sel_data;
            o_tlast  <= sel_last;
            o_tvalid <= 1'b1;
        end else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_packet_arb4.sv
// Directed bench for axi_packet_arb4: a full-mask and a 4'b0101-mask instance
// share the same input streams; expected values are hand-derived per phase.
module tb_axi_packet_arb4;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          o_tready;
    logic [W-1:0]  i_tdata [4];
    logic          i_tlast [4];
    logic          i_tvalid [4];
    wire  [3:0]    i_tready;
    wire  [W-1:0]  o_tdata;
    wire           o_tlast, o_tvalid;
    wire  [3:0]    grant;

    wire  [3:0]    m_tready;
    wire  [W-1:0]  m_tdata;
    wire           m_tlast, m_tvalid;
    wire  [3:0]    m_grant;

    always #5 clk = ~clk;

    axi_packet_arb4 #(.WIDTH(W), .ACTIVE_MASK(4'b1111)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .i0_tdata(i_tdata[0]), .i0_tlast(i_tlast[0]), .i0_tvalid(i_tvalid[0]), .i0_tready(i_tready[0]),
        .i1_tdata(i_tdata[1]), .i1_tlast(i_tlast[1]), .i1_tvalid(i_tvalid[1]), .i1_tready(i_tready[1]),
        .i2_tdata(i_tdata[2]), .i2_tlast(i_tlast[2]), .i2_tvalid(i_tvalid[2]), .i2_tready(i_tready[2]),
        .i3_tdata(i_tdata[3]), .i3_tlast(i_tlast[3]), .i3_tvalid(i_tvalid[3]), .i3_tready(i_tready[3]),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .grant(grant)
    );

    axi_packet_arb4 #(.WIDTH(W), .ACTIVE_MASK(4'b0101)) dut_masked (
        .clk(clk), .reset(reset), .clear(clear),
        .i0_tdata(i_tdata[0]), .i0_tlast(i_tlast[0]), .i0_tvalid(i_tvalid[0]), .i0_tready(m_tready[0]),
        .i1_tdata(i_tdata[1]), .i1_tlast(i_tlast[1]), .i1_tvalid(i_tvalid[1]), .i1_tready(m_tready[1]),
        .i2_tdata(i_tdata[2]), .i2_tlast(i_tlast[2]), .i2_tvalid(i_tvalid[2]), .i2_tready(m_tready[2]),
        .i3_tdata(i_tdata[3]), .i3_tlast(i_tlast[3]), .i3_tvalid(i_tvalid[3]), .i3_tready(m_tready[3]),
        .o_tdata(m_tdata), .o_tlast(m_tlast), .o_tvalid(m_tvalid), .o_tready(1'b1),
        .grant(m_grant)
    );

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;
    int cyc         = 0;
    int m_bad       = 0;
    int src_base [4];
    int src_len  [4];
    int src_bidx [4];
    bit src_en;
    bit toggle;

    logic [W-1:0] obs_d [$];
    logic         obs_l [$];
    int           obs_c [$];
    logic [3:0]   g_q   [$];
    int           gc_q  [$];
    logic [3:0]   mg_q  [$];
    logic [3:0]   prev_grant, prev_m_grant;
    bit           hold_pending;
    logic [W-1:0] hold_d;
    logic         hold_l;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        assert (got === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_pkt(input int p, input int base, input int len);
        src_base[p] = base;
        src_len[p]  = len;
        src_bidx[p] = 0;
        i_tdata[p]  = W'(base);
        i_tlast[p]  = (len == 1);
        i_tvalid[p] = 1'b1;
    endtask

    // One clock: sample handshakes, advance the edge, then advance each source.
    task automatic step_cycle();
        logic [3:0] hs;
        #2;
        for (int i = 0; i < 4; i++) hs[i] = i_tvalid[i] && i_tready[i];
        if (m_tready[1] || m_tready[3]) m_bad++;
        if (o_tvalid && o_tready) begin
            obs_d.push_back(o_tdata);
            obs_l.push_back(o_tlast);
            obs_c.push_back(cyc);
        end
        hold_pending = o_tvalid && !o_tready;
        hold_d       = o_tdata;
        hold_l       = o_tlast;
        tick();
        if (hold_pending) begin
            check_output("hold_valid", 32'(o_tvalid), 32'd1);
            check_output("hold_data",  32'(o_tdata), 32'(hold_d));
            check_output("hold_last",  32'(o_tlast), 32'(hold_l));
        end
        if (grant != 4'b0000 && prev_grant == 4'b0000) begin
            g_q.push_back(grant);
            gc_q.push_back(cyc);
        end
        if (m_grant != 4'b0000 && prev_m_grant == 4'b0000) mg_q.push_back(m_grant);
        prev_grant   = grant;
        prev_m_grant = m_grant;
        if (src_en) begin
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) begin
                    src_bidx[i]++;
                    if (src_bidx[i] >= src_len[i]) begin
                        i_tvalid[i] = 1'b0;
                    end else begin
                        i_tdata[i] = W'(src_base[i] + src_bidx[i]);
                        i_tlast[i] = (src_bidx[i] == src_len[i] - 1);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_tvalid[i] = 1'b0;
            i_tlast[i]  = 1'b0;
            i_tdata[i]  = '0;
            src_bidx[i] = 0;
            src_len[i]  = 0;
            src_base[i] = 0;
        end
        src_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        prev_grant   = 4'b0000;
        prev_m_grant = 4'b0000;
        m_bad        = 0;
        obs_d.delete();
        obs_l.delete();
        obs_c.delete();
        g_q.delete();
        gc_q.delete();
        mg_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        o_tready = 1'b1;
        src_en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_tvalid[i] = 1'b0;
            i_tlast[i]  = 1'b0;
            i_tdata[i]  = '0;
        end
        tick();
        tick();

        // Reset values, and tready held low while reset is asserted.
        check_output("rst_valid", 32'(o_tvalid), 32'd0);
        check_output("rst_grant", 32'(grant), 32'd0);
        check_output("rst_data",  32'(o_tdata), 32'd0);
        check_output("rst_last",  32'(o_tlast), 32'd0);
        for (int i = 0; i < 4; i++) i_tvalid[i] = 1'b1;
        #1;
        check_output("rst_tready",   32'(i_tready), 32'd0);
        check_output("rst_m_tready", 32'(m_tready), 32'd0);
        for (int i = 0; i < 4; i++) i_tvalid[i] = 1'b0;

        // Idle with no requests stays idle.
        do_reset();
        repeat (3) step_cycle();
        check_output("idle_grant", 32'(grant), 32'd0);
        check_output("idle_valid", 32'(o_tvalid), 32'd0);

        // Four simultaneous 3-beat packets served in order 0..3.
        do_reset();
        for (int p = 0; p < 4; p++) load_pkt(p, p * 16, 3);
        repeat (30) step_cycle();
        check_output("rr_grant_cnt", 32'(g_q.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < g_q.size()) check_output("rr_grant_order", 32'(g_q[k]), 32'(4'b0001 << k));
        check_output("rr_beat_cnt", 32'(obs_d.size()), 32'd12);
        for (int k = 0; k < 12; k++) begin
            if (k < obs_d.size() && gc_q.size() > 0) begin
                check_output("rr_data",  32'(obs_d[k]), 32'((k / 3) * 16 + (k % 3)));
                check_output("rr_last",  32'(obs_l[k]), 32'((k % 3) == 2));
                check_output("rr_cycle", 32'(obs_c[k] - gc_q[0]), 32'(4 * (k / 3) + (k % 3) + 1));
            end
        end

        // Single-beat packets on every input; masked instance only alternates 0 and 2.
        do_reset();
        src_en = 1'b0;
        for (int p = 0; p < 4; p++) begin
            i_tvalid[p] = 1'b1;
            i_tlast[p]  = 1'b1;
            i_tdata[p]  = W'(p);
        end
        repeat (16) step_cycle();
        src_en = 1'b1;
        check_output("mask_bad_tready", 32'(m_bad), 32'd0);
        check_output("mask_grant_cnt_ge4", 32'(mg_q.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++)
            if (k < mg_q.size()) check_output("mask_grant", 32'(mg_q[k]), (k % 2 == 1) ? 32'h4 : 32'h1);
        for (int k = 0; k < 4; k++)
            if (k < g_q.size()) check_output("single_grant", 32'(g_q[k]), 32'(4'b0001 << k));
        for (int k = 0; k < 3; k++)
            if (k + 1 < gc_q.size()) check_output("single_period", 32'(gc_q[k + 1] - gc_q[k]), 32'd2);
        for (int i = 0; i < 4; i++) i_tvalid[i] = 1'b0;

        // 4-beat packet on input 1 with output backpressure toggling every cycle.
        do_reset();
        load_pkt(1, 'hA1, 4);
        toggle = 1'b1;
        repeat (20) begin
            o_tready = toggle;
            step_cycle();
            toggle = !toggle;
        end
        o_tready = 1'b1;
        check_output("bp_beat_cnt", 32'(obs_d.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_d.size()) begin
                check_output("bp_data", 32'(obs_d[k]), 32'('hA1 + k));
                check_output("bp_last", 32'(obs_l[k]), 32'(k == 3));
            end
        end

        // Input 2 stalls mid-packet; input 0 must wait for its tlast.
        do_reset();
        o_tready = 1'b1;
        for (int n = 0; n < 10 && src_bidx[2] < 2; n++) step_cycle();
        load_pkt(2, 'h50, 4);
        for (int n = 0; n < 10 && src_bidx[2] < 2; n++) step_cycle();
        check_output("stall_progress", 32'(src_bidx[2]), 32'd2);
        load_pkt(0, 'h60, 1);
        src_bidx[2] = 2;
        i_tdata[2]  = W'('h52);
        i_tlast[2]  = 1'b0;
        i_tvalid[2] = 1'b0;
        repeat (5) begin
            step_cycle();
            #1;
            check_output("stall_grant",   32'(grant), 32'h4);
            check_output("stall_tready0", 32'(i_tready[0]), 32'd0);
        end
        i_tvalid[2] = 1'b1;
        for (int n = 0; n < 10 && i_tvalid[2]; n++) begin
            step_cycle();
            #1;
            if (i_tvalid[2]) check_output("resume_tready0", 32'(i_tready[0]), 32'd0);
        end
        check_output("stall_i2_done", 32'(i_tvalid[2]), 32'd0);
        repeat (6) step_cycle();
        check_output("stall_i0_done", 32'(i_tvalid[0]), 32'd0);
        check_output("stall_beat_cnt", 32'(obs_d.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            if (k < obs_d.size()) check_output("stall_data", 32'(obs_d[k]), (k < 4) ? 32'('h50 + k) : 32'h60);

        // Clear on the second beat of an input-3 packet truncates it.
        do_reset();
        o_tready = 1'b1;
        load_pkt(3, 'h70, 4);
        for (int n = 0; n < 10 && src_bidx[3] < 1; n++) step_cycle();
        check_output("clr_progress", 32'(src_bidx[3]), 32'd1);
        clear = 1'b1;
        load_pkt(0, 'h90, 2);
        step_cycle();
        clear = 1'b0;
        check_output("clr_valid", 32'(o_tvalid), 32'd0);
        check_output("clr_grant", 32'(grant), 32'd0);
        step_cycle();
        check_output("post_clr_grant", 32'(grant), 32'h1);
        repeat (12) step_cycle();
        for (int i = 0; i < 4; i++) i_tvalid[i] = 1'b0;

        // Asynchronous reset while a beat is waiting on the output.
        do_reset();
        o_tready = 1'b0;
        load_pkt(1, 'h80, 4);
        for (int n = 0; n < 10 && !o_tvalid; n++) step_cycle();
        check_output("pre_rst_valid", 32'(o_tvalid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check_output("async_rst_valid",  32'(o_tvalid), 32'd0);
        check_output("async_rst_grant",  32'(grant), 32'd0);
        check_output("async_rst_data",   32'(o_tdata), 32'd0);
        check_output("async_rst_tready", 32'(i_tready), 32'd0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) i_tvalid[i] = 1'b0;
        reset    = 1'b0;
        o_tready = 1'b1;
        obs_d.delete();
        repeat (3) step_cycle();
        check_output("post_rst_valid", 32'(o_tvalid), 32'd0);
        check_output("post_rst_beats", 32'(obs_d.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
